fsic_wb_initiator: RTL and testbench
====================================

# fsic_wb_initiator

Wishbone classic-cycle initiator that drives the FSIC management-side Wishbone slave port (`wbs_*`) from a simple command/response stream. It serves as the bench-side and SoC-side counterpart of the FSIC slave, turning one command into exactly one single-beat Wishbone cycle. A bounded ack timeout guarantees the initiator never hangs on a silent responder.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum number of bus cycles to wait for `wbm_ack_i`; 0 disables the timeout.
- `TO_W`, 8: width of the timeout counter; must satisfy `TIMEOUT` < 2^`TO_W`.

Ports:
- `wb_clk`  in  1  single clock for the whole block.
- `wb_rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on `cmd_valid & cmd_ready`.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_adr`  in  32  byte address.
- `cmd_wdata`  in  32  write data.
- `cmd_sel`  in  4  byte lane selects.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed on `rsp_valid & rsp_ready`.
- `rsp_rdata`  out  32  read data.
- `rsp_err`  out  1  1 = timeout.
- `rsp_we`  out  1  echo of the command's `we`.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone controls.
- `wbm_sel_o`  out  4  byte selects.
- `wbm_adr_o`  out  32  address.
- `wbm_dat_o`  out  32  write data.
- `wbm_ack_i`  in  1  responder acknowledge.
- `wbm_dat_i`  in  32  responder read data.
- `busy`  out  1  high whenever the block is not IDLE.

## Operation
- **FSM states:** IDLE, BUS, RESP. All outputs are registered.
- **IDLE**
  - `cmd_ready` = 1.
  - On the accept edge, latch `we`/`adr`/`wdata`/`sel` into the `wbm_*` output registers and set `wbm_cyc_o` = `wbm_stb_o` = 1.
  - Clear the timer and go to BUS.
- **BUS**
  - `cmd_ready` = 0.
  - All `wbm_*` outputs are held stable.
  - The timer increments every cycle in which ack is not sampled.
- **Ack sampled high:**
  - Clear cyc/stb.
  - `rsp_rdata` = `wbm_dat_i` for a read, 32'h0 for a write.
  - `rsp_err` = 0.
  - Go to RESP.
- **Timeout:** `TIMEOUT` ≠ 0, timer == `TIMEOUT`-1 and no ack.
  - Clear cyc/stb.
  - `rsp_rdata` = 32'hFFFF_FFFF.
  - `rsp_err` = 1.
  - Go to RESP.
- **Ack on the terminal timer cycle:** ack wins; `rsp_err` = 0.
- **RESP**
  - `rsp_valid` = 1; `rsp_rdata`, `rsp_err`, `rsp_we` are held until the handshake.
  - On the handshake edge, go to IDLE.
  - `wbm_cyc_o` and `wbm_stb_o` stay 0.
- **Spurious ack:** `wbm_ack_i` in IDLE or RESP is ignored.
- **Timer width:** wrap-around is impossible because `TIMEOUT` < 2^`TO_W`. With `TIMEOUT` = 0 the timer is frozen and the block waits for ack indefinitely.
- **`wbm_we_o`, `wbm_adr_o`, `wbm_dat_o`, `wbm_sel_o`** keep their last values after a cycle ends; responders must qualify them with cyc/stb.
- **Reset (async, any state, including mid-cycle):**
  - The state returns to IDLE immediately.
  - All outputs go to 0: `wbm_*`, `rsp_*`, `busy`. The exception is `cmd_ready`, which is 0 while `wb_rst_n` = 0 and becomes 1 on the first edge after release.
  - A cycle in flight is abandoned without a response.

## Timing
- **Accept edge T:** cyc/stb are visible after T.
- **Zero-wait responder** (ack high in the first BUS cycle):
  - Ack is sampled at T+1.
  - Cyc/stb drop and `rsp_valid` rises after T+1.
- **Back-to-back throughput:** with `rsp_ready` held high, `cmd_ready` returns after T+2, giving 3 cycles per transaction.
- **N wait states:** cyc/stb stay high for N+1 cycles; `rsp_valid` follows N+1 cycles after T.
- **Timeout:** cyc/stb stay high exactly `TIMEOUT` cycles; `rsp_valid` follows `TIMEOUT` cycles after T.
- **No pipelining:** `cmd_ready` is never high while `rsp_valid` = 1 or cyc = 1, so there is only one outstanding transaction.

## Test plan
- **Reset:**
  - Assert `wb_rst_n` = 0 while cyc = 1 in BUS -> cyc/stb/`rsp_valid`/`busy`/`cmd_ready` = 0 immediately.
  - After release -> `cmd_ready` = 1 at the next edge.
- **Zero-wait write:**
  - Write `adr`=0x3000_0004, `wdata`=0xA5A5_1234, `sel`=0xF; responder acks immediately.
  - Required: cyc high 1 cycle with the exact `wbm_*` values; `rsp_valid` 1 cycle after accept with `rsp_err`=0, `rsp_we`=1, `rsp_rdata`=0.
- **Wait-state read:**
  - Read `adr`=0x3000_0010; responder acks after 3 wait states with `dat`=0xDEAD_BEEF.
  - Required: cyc high 4 cycles; `rsp_rdata`=0xDEAD_BEEF; `rsp_err`=0.
- **Timeout, including the boundary case:**
  - `TIMEOUT`=8, silent responder -> cyc high exactly 8 cycles; `rsp_err`=1; `rsp_rdata`=0xFFFF_FFFF.
  - Repeat with ack on the 8th cycle -> `rsp_err`=0.
- **Backpressure:**
  - Hold `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - Required: response fields stable; `cmd_ready`=0 and cyc=0 throughout.
  - A new `cmd_valid` is not accepted until 1 edge after the response handshake.
- **Stream and spurious ack:**
  - Run 100 random back-to-back read/write commands against a memory model with random 0–4 wait states.
  - Required: all read data matches, and a zero-wait run takes 3 cycles per transaction.
  - Pulse `wbm_ack_i` in IDLE -> no state change.

Source files
------------

// File: rtl/fsic_wb_initiator.sv
// fsic_wb_initiator
// Turns one command from a valid/ready command stream into one single-beat
// Wishbone classic cycle, then returns one response on a valid/ready
// response stream. An optional ack timeout ends a cycle that the responder
// never acknowledges and reports it as an error response.
//
// Handshake rule for both streams: a transfer happens on a rising wb_clk edge
// where valid and ready are both high; valid never waits on ready, and
// the payload is held stable while valid is high and ready is low.
//
// TIMEOUT must be smaller than 2**TO_W so that the timer never wraps.
// TIMEOUT == 0 disables the timeout, and the timer then stays frozen.

module fsic_wb_initiator #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,

    // command stream
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_sel,

    // response stream
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_we,

    // Wishbone initiator port
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,

    // status
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Value of the timer on the last cycle a silent responder is allowed.
    localparam int unsigned   TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_LAST_I[TO_W-1:0];
    localparam bit            TO_EN     = (TIMEOUT != 0);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] timer;
    logic [TO_W-1:0] timer_nxt;

    logic            accept;
    logic            ack_hit;
    logic            to_hit;
    logic            rsp_done;

    // next values of the registered outputs
    logic            cmd_ready_nxt;
    logic            rsp_valid_nxt;
    logic [31:0]     rsp_rdata_nxt;
    logic            rsp_err_nxt;
    logic            rsp_we_nxt;
    logic            wbm_cyc_nxt;
    logic            wbm_stb_nxt;
    logic            wbm_we_nxt;
    logic [3:0]      wbm_sel_nxt;
    logic [31:0]     wbm_adr_nxt;
    logic [31:0]     wbm_dat_nxt;
    logic            busy_nxt;

    // Handshake and bus events. Ack outside BUS is ignored; ack on the
    // terminal timer cycle wins over the timeout.
    assign accept   = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign ack_hit  = (state == ST_BUS) && wbm_ack_i;
    assign to_hit   = TO_EN && (state == ST_BUS) && !wbm_ack_i && (timer == TO_LAST);
    assign rsp_done = (state == ST_RESP) && rsp_valid && rsp_ready;

    assign dbg_state = state;

    // State register.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)            state_nxt = ST_BUS;
            ST_BUS:  if (ack_hit || to_hit) state_nxt = ST_RESP;
            ST_RESP: if (rsp_done)          state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: computes the next value of every registered output and
    // of the ack timer from the current state and the bus events.
    always_comb begin
        timer_nxt     = timer;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        rsp_we_nxt    = rsp_we;
        wbm_cyc_nxt   = wbm_cyc_o;
        wbm_stb_nxt   = wbm_stb_o;
        wbm_we_nxt    = wbm_we_o;
        wbm_sel_nxt   = wbm_sel_o;
        wbm_adr_nxt   = wbm_adr_o;
        wbm_dat_nxt   = wbm_dat_o;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    wbm_we_nxt  = cmd_we;
                    wbm_adr_nxt = cmd_adr;
                    wbm_dat_nxt = cmd_wdata;
                    wbm_sel_nxt = cmd_sel;
                    wbm_cyc_nxt = 1'b1;
                    wbm_stb_nxt = 1'b1;
                    timer_nxt   = '0;
                end
            end
            ST_BUS: begin
                if (ack_hit) begin
                    wbm_cyc_nxt   = 1'b0;
                    wbm_stb_nxt   = 1'b0;
                    rsp_rdata_nxt = wbm_we_o ? 32'h0 : wbm_dat_i;
                    rsp_err_nxt   = 1'b0;
                    rsp_we_nxt    = wbm_we_o;
                end else if (to_hit) begin
                    wbm_cyc_nxt   = 1'b0;
                    wbm_stb_nxt   = 1'b0;
                    rsp_rdata_nxt = 32'hFFFF_FFFF;
                    rsp_err_nxt   = 1'b1;
                    rsp_we_nxt    = wbm_we_o;
                end else if (TO_EN) begin
                    timer_nxt = timer + TO_W'(1);
                end
            end
            ST_RESP: begin
                // Response fields and bus lines simply hold here.
                wbm_cyc_nxt = 1'b0;
                wbm_stb_nxt = 1'b0;
            end
            default: begin
                wbm_cyc_nxt = 1'b0;
                wbm_stb_nxt = 1'b0;
            end
        endcase

        cmd_ready_nxt = (state_nxt == ST_IDLE);
        rsp_valid_nxt = (state_nxt == ST_RESP);
        busy_nxt      = (state_nxt != ST_IDLE);
    end

    // Output and timer registers; everything, including cmd_ready, is zero
    // while reset is asserted.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            timer     <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            rsp_we    <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
            busy      <= 1'b0;
        end else begin
            timer     <= timer_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_we    <= rsp_we_nxt;
            wbm_cyc_o <= wbm_cyc_nxt;
            wbm_stb_o <= wbm_stb_nxt;
            wbm_we_o  <= wbm_we_nxt;
            wbm_sel_o <= wbm_sel_nxt;
            wbm_adr_o <= wbm_adr_nxt;
            wbm_dat_o <= wbm_dat_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_fsic_wb_initiator.sv
// Testbench for fsic_wb_initiator (TIMEOUT = 8).
// A behavioural Wishbone responder with a sparse memory answers the cycles;
// a separate reference memory predicts every response.

module tb_fsic_wb_initiator;

    localparam int TO = 8;

    logic        wb_clk    = 1'b0;
    logic        wb_rst_n  = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we    = 1'b0;
    logic [31:0] cmd_adr   = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic [3:0]  cmd_sel   = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_we;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        busy;
    logic [1:0]  dbg_state;

    fsic_wb_initiator #(.TIMEOUT(TO), .TO_W(8)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_we(rsp_we),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 wb_clk = ~wb_clk;

    int cycle = 0;
    always @(posedge wb_clk) cycle <= cycle + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- memory helpers ----------------
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // ---------------- responder ----------------
    logic [31:0] resp_mem [logic [31:0]];
    int          resp_wait   = 0;
    bit          resp_silent = 1'b0;
    bit          force_ack   = 1'b0;
    int          cnt         = 0;
    int          last_len    = 0;
    bit          stable_err  = 1'b0;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;

    // Acks after resp_wait wait states; counts how many cycles cyc was high
    // and flags any change of the bus lines while the cycle is open.
    always @(negedge wb_clk) begin
        if (wbm_cyc_o && wbm_stb_o) begin
            cnt = cnt + 1;
            if (cnt == 1) begin
                cap_adr = wbm_adr_o; cap_dat = wbm_dat_o;
                cap_we  = wbm_we_o;  cap_sel = wbm_sel_o;
            end else if (cap_adr !== wbm_adr_o || cap_dat !== wbm_dat_o ||
                         cap_we !== wbm_we_o || cap_sel !== wbm_sel_o) begin
                stable_err = 1'b1;
            end
            if (!resp_silent && cnt == resp_wait + 1) begin
                wbm_ack_i = 1'b1;
                if (wbm_we_o) begin
                    resp_mem[wbm_adr_o] = merge(resp_mem.exists(wbm_adr_o) ? resp_mem[wbm_adr_o]
                                                : init_val(wbm_adr_o), wbm_dat_o, wbm_sel_o);
                    wbm_dat_i = $urandom;
                end else begin
                    wbm_dat_i = resp_mem.exists(wbm_adr_o) ? resp_mem[wbm_adr_o] : init_val(wbm_adr_o);
                end
            end else begin
                wbm_ack_i = force_ack;
                wbm_dat_i = $urandom;
            end
        end else begin
            if (cnt > 0) last_len = cnt;
            cnt       = 0;
            wbm_ack_i = force_ack;
            wbm_dat_i = $urandom;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // ---------------- driver tasks ----------------
    bit          run_ok;
    int          accept_cycle;
    logic [31:0] got_rdata;
    logic        got_err, got_we;

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                            input logic [3:0] sel, output bit ok);
        cmd_we = we; cmd_adr = adr; cmd_wdata = wd; cmd_sel = sel; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge wb_clk);
            if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_wait: cmd_ready=%b, required 1 within 50 cycles", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge wb_clk);
        #1;
        accept_cycle = cycle;
        cmd_valid = 1'b0;
    endtask

    // Returns n = number of edges after the accept edge until rsp_valid shows.
    task automatic wait_rsp(output int n, output bit ok);
        ok = 1'b0; n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge wb_clk);
            if (rsp_valid === 1'b1) begin ok = 1'b1; n = i; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_wait: rsp_valid=%b, required 1 within 300 cycles", rsp_valid);
            return;
        end
        got_rdata = rsp_rdata; got_err = rsp_err; got_we = rsp_we;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge wb_clk);
        #1;
    endtask

    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           input logic [3:0] sel, input int wait_n, input bit silent,
                           output int lat);
        bit ok;
        lat = -1;
        resp_wait = wait_n; resp_silent = silent; stable_err = 1'b0;
        run_ok = 1'b0;
        send_cmd(we, adr, wd, sel, ok);
        if (!ok) return;
        wait_rsp(lat, ok);
        if (!ok) return;
        finish_rsp();
        run_ok = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit ok;
        rsp_ready = 1'b1; cmd_valid = 1'b0;
        repeat (3) @(negedge wb_clk);
        n_cmp++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
             rsp_valid, rsp_err, rsp_we, rsp_rdata, busy, cmd_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: cyc=%b stb=%b rv=%b busy=%b crdy=%b adr=%h, required all 0",
                     wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready, wbm_adr_o);
        end
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
        end

        // reset in the middle of a bus cycle
        resp_silent = 1'b1;
        send_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF, ok);
        @(negedge wb_clk);
        n_cmp++;
        if (wbm_cyc_o !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_cycle_pre: cyc=%b busy=%b, required 1/1", wbm_cyc_o, busy);
        end
        #2 wb_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready} !== 5'b0) begin
            n_bad++;
            $display("FAIL mid_cycle_reset: cyc=%b stb=%b rv=%b busy=%b crdy=%b, required all 0",
                     wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready);
        end
        @(negedge wb_clk);
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_hold: cmd_ready=%b, required 0", cmd_ready);
        end
        wb_rst_n = 1'b1;
        resp_silent = 1'b0;
        @(negedge wb_clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release2: crdy=%b rv=%b cyc=%b, required 1/0/0", cmd_ready, rsp_valid, wbm_cyc_o);
        end
    endtask

    task automatic test_zero_wait_write();
        int lat;
        ref_mem[32'h3000_0004] = merge(ref_read(32'h3000_0004), 32'hA5A5_1234, 4'hF);
        run_cmd(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 1'b0, lat);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL wr_latency: got %0d required 1", lat); end
        n_cmp++;
        if (last_len !== 1) begin n_bad++; $display("FAIL wr_cyc_len: got %0d required 1", last_len); end
        n_cmp++;
        if (cap_adr !== 32'h3000_0004 || cap_dat !== 32'hA5A5_1234 || cap_we !== 1'b1 || cap_sel !== 4'hF) begin
            n_bad++;
            $display("FAIL wr_bus_fields: adr=%h dat=%h we=%b sel=%h, required 30000004/a5a51234/1/f",
                     cap_adr, cap_dat, cap_we, cap_sel);
        end
        n_cmp++;
        if (got_err !== 1'b0 || got_we !== 1'b1 || got_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL wr_rsp: err=%b we=%b rdata=%h, required 0/1/00000000", got_err, got_we, got_rdata);
        end
        n_cmp++;
        if (resp_mem[32'h3000_0004] !== ref_read(32'h3000_0004)) begin
            n_bad++; $display("FAIL wr_mem: got %h required %h", resp_mem[32'h3000_0004], ref_read(32'h3000_0004));
        end
    endtask

    task automatic test_wait_read();
        int lat;
        resp_mem[32'h3000_0010] = 32'hDEAD_BEEF;
        ref_mem[32'h3000_0010]  = 32'hDEAD_BEEF;
        run_cmd(1'b0, 32'h3000_0010, $urandom, 4'hF, 3, 1'b0, lat);
        n_cmp++;
        if (lat !== 4 || last_len !== 4) begin
            n_bad++; $display("FAIL rd_wait_timing: lat=%0d cyc_len=%0d, required 4/4", lat, last_len);
        end
        n_cmp++;
        if (got_rdata !== 32'hDEAD_BEEF || got_err !== 1'b0 || got_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_wait_rsp: rdata=%h err=%b we=%b, required deadbeef/0/0", got_rdata, got_err, got_we);
        end
        n_cmp++;
        if (stable_err !== 1'b0 || cap_adr !== 32'h3000_0010 || cap_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_wait_bus: unstable=%b adr=%h we=%b, required 0/30000010/0", stable_err, cap_adr, cap_we);
        end
    endtask

    task automatic test_timeout();
        int lat;
        run_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 1'b1, lat);
        n_cmp++;
        if (lat !== TO || last_len !== TO) begin
            n_bad++; $display("FAIL to_timing: lat=%0d cyc_len=%0d, required %0d/%0d", lat, last_len, TO, TO);
        end
        n_cmp++;
        if (got_err !== 1'b1 || got_rdata !== 32'hFFFF_FFFF || got_we !== 1'b0) begin
            n_bad++;
            $display("FAIL to_rsp: err=%b rdata=%h we=%b, required 1/ffffffff/0", got_err, got_rdata, got_we);
        end
        run_cmd(1'b1, 32'h3000_0024, 32'h1111_2222, 4'h3, 0, 1'b1, lat);
        n_cmp++;
        if (lat !== TO || got_err !== 1'b1 || got_rdata !== 32'hFFFF_FFFF || got_we !== 1'b1) begin
            n_bad++;
            $display("FAIL to_wr_rsp: lat=%0d err=%b rdata=%h we=%b, required %0d/1/ffffffff/1",
                     lat, got_err, got_rdata, got_we, TO);
        end
    endtask

    task automatic test_ack_boundary();
        int lat;
        run_cmd(1'b0, 32'h3000_0028, 32'h0, 4'hF, TO - 1, 1'b0, lat);
        n_cmp++;
        if (lat !== TO || last_len !== TO) begin
            n_bad++; $display("FAIL bnd_timing: lat=%0d cyc_len=%0d, required %0d/%0d", lat, last_len, TO, TO);
        end
        n_cmp++;
        if (got_err !== 1'b0 || got_rdata !== ref_read(32'h3000_0028)) begin
            n_bad++;
            $display("FAIL bnd_rsp: err=%b rdata=%h, required 0/%h", got_err, got_rdata, ref_read(32'h3000_0028));
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok;
        logic [31:0] r0;
        logic e0, w0;
        rsp_ready = 1'b0;
        resp_wait = 1; resp_silent = 1'b0;
        send_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF, ok);
        wait_rsp(lat, ok);
        r0 = got_rdata; e0 = got_err; w0 = got_we;
        n_cmp++;
        if (r0 !== ref_read(32'h3000_0030) || e0 !== 1'b0) begin
            n_bad++; $display("FAIL bp_first: rdata=%h err=%b, required %h/0", r0, e0, ref_read(32'h3000_0030));
        end
        // next command is already waiting while the response is stalled
        cmd_we = 1'b0; cmd_adr = 32'h3000_0034; cmd_wdata = 32'h0; cmd_sel = 4'hF; cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) force_ack = 1'b1;   // spurious ack while in RESP
            if (k == 3) force_ack = 1'b0;
            @(negedge wb_clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 || rsp_we !== w0 ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold%0d: rv=%b rdata=%h err=%b crdy=%b cyc=%b, required 1/%h/%b/0/0",
                         k, rsp_valid, rsp_rdata, rsp_err, cmd_ready, wbm_cyc_o, r0, e0);
            end
        end
        force_ack = 1'b0;
        rsp_ready = 1'b1;
        @(posedge wb_clk);
        @(negedge wb_clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_after_hs: rv=%b crdy=%b cyc=%b, required 0/1/0", rsp_valid, cmd_ready, wbm_cyc_o);
        end
        resp_wait = 0;
        @(posedge wb_clk);
        #1 cmd_valid = 1'b0;
        @(negedge wb_clk);
        n_cmp++;
        if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h3000_0034) begin
            n_bad++; $display("FAIL bp_second_accept: cyc=%b adr=%h, required 1/30000034", wbm_cyc_o, wbm_adr_o);
        end
        wait_rsp(lat, ok);
        finish_rsp();
        n_cmp++;
        if (got_rdata !== ref_read(32'h3000_0034) || got_err !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_second_rsp: rdata=%h err=%b, required %h/0", got_rdata, got_err, ref_read(32'h3000_0034));
        end
    endtask

    task automatic test_stream();
        int lat, wt;
        logic we;
        logic [31:0] adr, wd, exp_rd;
        logic [3:0] sel;
        int prev_acc;
        for (int t = 0; t < 100; t++) begin
            adr = 32'h3000_0100 + 32'($urandom_range(0, 15)) * 4;
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            sel = 4'($urandom_range(1, 15));
            wt  = $urandom_range(0, 4);
            if (we) begin
                ref_mem[adr] = merge(ref_read(adr), wd, sel);
                exp_rd = 32'h0;
            end else begin
                exp_rd = ref_read(adr);
            end
            run_cmd(we, adr, wd, sel, wt, 1'b0, lat);
            n_cmp++;
            if (!run_ok || got_rdata !== exp_rd || got_err !== 1'b0 || got_we !== we || lat !== wt + 1) begin
                n_bad++;
                $display("FAIL stream%0d: we=%b adr=%h rdata=%h err=%b lat=%0d, required rdata=%h err=0 lat=%0d",
                         t, we, adr, got_rdata, got_err, lat, exp_rd, wt + 1);
            end
        end
        prev_acc = 0;
        for (int t = 0; t < 10; t++) begin
            adr = 32'h3000_0100 + 32'(t) * 4;
            run_cmd(1'b0, adr, 32'h0, 4'hF, 0, 1'b0, lat);
            if (t > 0) begin
                n_cmp++;
                if (accept_cycle - prev_acc !== 3) begin
                    n_bad++;
                    $display("FAIL throughput%0d: %0d cycles per transaction, required 3", t, accept_cycle - prev_acc);
                end
            end
            prev_acc = accept_cycle;
        end
    endtask

    task automatic test_spurious_ack();
        @(posedge wb_clk);
        #1 force_ack = 1'b1;
        @(posedge wb_clk);
        #1 force_ack = 1'b0;
        @(negedge wb_clk);
        n_cmp++;
        if (busy !== 1'b0 || wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL spurious_idle: busy=%b cyc=%b rv=%b crdy=%b, required 0/0/0/1",
                     busy, wbm_cyc_o, rsp_valid, cmd_ready);
        end
    endtask

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_timeout();
        test_ack_boundary();
        test_backpressure();
        test_stream();
        test_spurious_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
